// File: rtl/data_mem_master.sv
// Request-driven master for Data_Memory: single-word writes and read bursts
// with one-cycle memory read latency.
module data_mem_master #(
  parameter int unsigned BURST_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [7:0]  req_addr,
  input  logic [3:0]  req_len,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_last,
  output logic        wr_done,
  output logic [7:0]  MemAddr,
  output logic [31:0] Write_Data,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] Read_Data
);

  localparam logic [4:0] BurstMax = 5'(BURST_MAX);

  typedef enum logic [1:0] {StIdle, StRdIssue, StRdDrain, StWr} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;      // issue cycles remaining after the current one
  logic        rd_pend_q;  // Read_Data carries a beat this cycle
  logic        rd_last_q;  // that beat is the final one
  logic [4:0]  len_p1;
  logic [4:0]  beats;
  logic [3:0]  burst_m1;

  always_comb begin
    len_p1   = {1'b0, req_len} + 5'd1;
    beats    = (len_p1 > BurstMax) ? BurstMax : len_p1;
    burst_m1 = 4'(beats - 5'd1);
  end

  assign req_ready = (state_q == StIdle);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rd_pend_q  <= 1'b0;
      rd_last_q  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_last   <= 1'b0;
      wr_done    <= 1'b0;
      MemAddr    <= '0;
      Write_Data <= '0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
    end else begin
      wr_done   <= 1'b0;
      // Beat pipeline: address cycle -> memory output cycle -> response cycle
      rd_pend_q <= MemRead;
      rd_last_q <= MemRead && (cnt_q == 4'd0);
      rsp_valid <= rd_pend_q;
      rsp_last  <= rd_pend_q && rd_last_q;
      if (rd_pend_q) rsp_rdata <= Read_Data;

      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            MemAddr <= req_addr;
            cnt_q   <= burst_m1;
            if (req_we) begin
              Write_Data <= req_wdata;
              MemWrite   <= 1'b1;
              state_q    <= StWr;
            end else begin
              MemRead <= 1'b1;
              state_q <= StRdIssue;
            end
          end
        end
        StWr: begin
          MemWrite <= 1'b0;
          wr_done  <= 1'b1;
          state_q  <= StIdle;
        end
        StRdIssue: begin
          if (cnt_q == 4'd0) begin
            MemRead <= 1'b0;
            state_q <= StRdDrain;
          end else begin
            MemAddr <= MemAddr + 8'd1;
            cnt_q   <= cnt_q - 4'd1;
          end
        end
        StRdDrain: begin
          if (rsp_last) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_master.sv
// Directed bench for data_mem_master: a BURST_MAX=16 instance with full checks and a
// BURST_MAX=4 instance sharing the request inputs for the burst-cap scenario.
module tb_data_mem_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [3:0]  req_len;
  logic [31:0] req_wdata;

  logic        req_ready, rsp_valid, rsp_last, wr_done, MemRead, MemWrite;
  logic [31:0] rsp_rdata, Write_Data, Read_Data;
  logic [7:0]  MemAddr;

  logic        req_ready_b, rsp_valid_b, rsp_last_b, wr_done_b, MemRead_b, MemWrite_b;
  logic [31:0] rsp_rdata_b, Write_Data_b, Read_Data_b;
  logic [7:0]  MemAddr_b;

  logic [31:0] mem     [256];
  logic [31:0] mem_b   [256];
  logic [31:0] ref_mem [256];

  int n_chk = 0;
  int n_err = 0;
  int rw_viol = 0;

  always #5 clk = ~clk;

  data_mem_master #(.BURST_MAX(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_last(rsp_last), .wr_done(wr_done), .MemAddr(MemAddr),
    .Write_Data(Write_Data), .MemRead(MemRead), .MemWrite(MemWrite), .Read_Data(Read_Data)
  );

  data_mem_master #(.BURST_MAX(4)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_b), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .rsp_valid(rsp_valid_b),
    .rsp_rdata(rsp_rdata_b), .rsp_last(rsp_last_b), .wr_done(wr_done_b), .MemAddr(MemAddr_b),
    .Write_Data(Write_Data_b), .MemRead(MemRead_b), .MemWrite(MemWrite_b),
    .Read_Data(Read_Data_b)
  );

  // Data_Memory models: synchronous write, registered read (one-cycle latency)
  always @(posedge clk) begin
    if (MemWrite) mem[MemAddr] <= Write_Data;
    if (MemRead) Read_Data <= mem[MemAddr];
    if (MemWrite_b) mem_b[MemAddr_b] <= Write_Data_b;
    if (MemRead_b) Read_Data_b <= mem_b[MemAddr_b];
  end

  always @(negedge clk) if (MemRead && MemWrite) rw_viol++;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rst();
    check("rst_ready", req_ready, 1);
    check("rst_memread", MemRead, 0);
    check("rst_memwrite", MemWrite, 0);
    check("rst_memaddr", MemAddr, 0);
    check("rst_wdata", Write_Data, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_last", rsp_last, 0);
    check("rst_wr_done", wr_done, 0);
  endtask

  // Returns in the first cycle after the accepting edge; inputs are then scrambled.
  task automatic do_req(input logic we, input logic [7:0] addr, input logic [3:0] len,
                        input logic [31:0] wdata);
    bit ok = 0;
    req_we = we; req_addr = addr; req_len = len; req_wdata = wdata; req_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (req_ready) begin
        ok = 1;
        break;
      end
      tick();
    end
    check("req_accept", 32'(ok), 1);
    tick();
    req_valid = 1'b0;
    req_we = ~we; req_addr = ~addr; req_len = ~len; req_wdata = ~wdata;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    do_req(1'b1, addr, 4'd0, data);
    check("wr_memwrite", MemWrite, 1);
    check("wr_memread", MemRead, 0);
    check("wr_addr", MemAddr, addr);
    check("wr_data", Write_Data, data);
    check("wr_busy", req_ready, 0);
    check("wr_done_early", wr_done, 0);
    tick();
    check("wr_done", wr_done, 1);
    check("wr_memwrite_off", MemWrite, 0);
    check("wr_ready", req_ready, 1);
    ref_mem[addr] = data;
  endtask

  task automatic rd(input logic [7:0] addr, input logic [3:0] len);
    int n;
    logic [7:0] a;
    logic [7:0] ad;
    n = int'(len) + 1;
    do_req(1'b0, addr, len, 32'h0);
    for (int c = 0; c <= n + 2; c++) begin
      a = addr + 8'(c);
      ad = addr + 8'(c - 2);
      if (c < n) begin
        check("rd_memread", MemRead, 1);
        check("rd_addr", MemAddr, a);
      end else begin
        check("rd_memread_off", MemRead, 0);
      end
      check("rd_memwrite", MemWrite, 0);
      if (c >= 2 && c <= n + 1) begin
        check("rsp_valid", rsp_valid, 1);
        check("rsp_data", rsp_rdata, ref_mem[ad]);
        check("rsp_last", rsp_last, 32'(c == n + 1));
      end else begin
        check("rsp_valid_idle", rsp_valid, 0);
        check("rsp_last_idle", rsp_last, 0);
      end
      check("rd_ready", req_ready, 32'(c == n + 2));
      if (c < n + 2) tick();
    end
  endtask

  initial begin
    logic [7:0] pre [8];
    logic [7:0] a;
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_len = '0; req_wdata = '0;
    pre[0] = 8'hFE; pre[1] = 8'hFF; pre[2] = 8'h00; pre[3] = 8'h01;
    pre[4] = 8'h10; pre[5] = 8'h11; pre[6] = 8'h12; pre[7] = 8'h13;
    repeat (3) tick();
    check_rst();
    reset = 1'b1;

    // Write then single-beat read-back, accepted on the first edge after release
    wr(8'h40, 32'hDEADBEEF);
    tick();
    check("wr_done_pulse", wr_done, 0);
    check("hold_addr", MemAddr, 8'h40);
    check("hold_wdata", Write_Data, 32'hDEADBEEF);
    rd(8'h40, 4'd0);

    // Wrapping burst across 0xFF -> 0x00
    for (int i = 0; i < 8; i++) wr(pre[i], 32'hA5000000 | {24'h0, pre[i]} | (32'(i) << 12));
    rd(8'hFE, 4'd3);

    // len 15 on both instances with req_valid held: BURST_MAX=4 gives 4 beats
    req_we = 1'b0; req_addr = 8'h10; req_len = 4'd15; req_wdata = '0; req_valid = 1'b1;
    check("b_ready_start", req_ready_b, 1);
    tick();
    for (int c = 0; c <= 6; c++) begin
      a = 8'h10 + 8'(c - 2);
      if (c >= 2 && c <= 5) begin
        check("b_valid", rsp_valid_b, 1);
        check("b_data", rsp_rdata_b, ref_mem[a]);
        check("b_last", rsp_last_b, 32'(c == 5));
      end else begin
        check("b_valid_idle", rsp_valid_b, 0);
      end
      check("b_ready", req_ready_b, 32'(c == 6));
      check("b_memread", MemRead_b, 32'(c < 4));
      check("b_wr_done", wr_done_b, 0);
      if (c < 6) tick();
    end
    check("a_still_busy", req_ready, 0);
    tick();
    check("b_reaccept", MemRead_b, 1);
    check("b_reaccept_addr", MemAddr_b, 8'h10);
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_rst();
    tick();
    reset = 1'b1;

    // Reset during the 3rd issue cycle of an 8-beat read
    do_req(1'b0, 8'h00, 4'd7, 32'h0);
    tick();
    tick();
    check("abort_pre_memread", MemRead, 1);
    check("abort_pre_addr", MemAddr, 8'h02);
    #2;
    reset = 1'b0;
    #1;
    check_rst();
    tick();
    tick();
    check("abort_no_valid", rsp_valid, 0);
    #2;
    reset = 1'b1;
    req_we = 1'b1; req_addr = 8'h55; req_wdata = 32'h12345678; req_valid = 1'b1;
    check("post_rst_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("post_rst_memwrite", MemWrite, 1);
    check("post_rst_addr", MemAddr, 8'h55);
    tick();
    check("post_rst_wr_done", wr_done, 1);
    ref_mem[8'h55] = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      check("post_rst_no_beat", rsp_valid, 0);
      tick();
    end

    // Random mix over a pre-written pool
    for (int i = 0; i < 16; i++) wr(8'h80 + 8'(i), $urandom);
    for (int i = 0; i < 30; i++) begin
      a = 8'h80 + 8'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) wr(a, $urandom);
      else rd(a, 4'($urandom_range(0, 5)));
    end
    rd(8'h55, 4'd0);

    check("rw_exclusive", rw_viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/data_mem_master.md
DATA_MEM_MASTER -- requirements
Module: data_mem_master

Interface
REQ-001 The block SHALL have parameter BURST_MAX, default 16, the maximum read burst length in words; legal values 1..16.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset (0 = in reset).
REQ-004 The block SHALL have port req_valid, input, 1, a request is presented.
REQ-005 The block SHALL have port req_ready, output, 1, the block accepts a request this cycle.
REQ-006 The block SHALL have port req_we, input, 1, 1 = single-word write, 0 = read burst.
REQ-007 The block SHALL have port req_addr, input, 8, start word address.
REQ-008 The block SHALL have port req_len, input, 4, read beats minus one; ignored for writes.
REQ-009 The block SHALL have port req_wdata, input, 32, write data.
REQ-010 The block SHALL have port rsp_valid, output, 1, one read beat on rsp_rdata.
REQ-011 The block SHALL have port rsp_rdata, output, 32, read data.
REQ-012 The block SHALL have port rsp_last, output, 1, final beat of the burst.
REQ-013 The block SHALL have port wr_done, output, 1, one-cycle pulse when a write completes.
REQ-014 The block SHALL have ports MemAddr (output, 8), Write_Data (output, 32), MemRead (output, 1), MemWrite (output, 1) and Read_Data (input, 32), which connect directly to Data_Memory.

Function
REQ-015 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; req_addr, req_len, req_we and req_wdata SHALL be captured at that edge.
REQ-016 The state machine SHALL have the states IDLE, RD_ISSUE, RD_DRAIN and WR, and req_ready SHALL be 1 only in IDLE.
REQ-017 The IDLE state SHALL go to WR on an accepted write and to RD_ISSUE on an accepted read.
REQ-018 The WR state SHALL last one cycle (MemWrite=1, MemAddr=addr, Write_Data=wdata) and then return to IDLE; wr_done SHALL be 1 in the following cycle.
REQ-019 The read burst length SHALL be N = min(req_len+1, BURST_MAX).
REQ-020 The RD_ISSUE state SHALL last N cycles, with MemRead=1 and MemAddr = start+k for beat k, taken mod 256 (0xFF wraps to 0x00).
REQ-021 The Read_Data input SHALL be sampled on the edge ending the cycle after its address was driven, giving one-cycle memory latency.
REQ-022 For beat k, rsp_rdata SHALL be the registered copy of Read_Data and rsp_valid SHALL be 1, giving rsp_valid high in cycles acc+2 .. acc+N+1.
REQ-023 The rsp_valid beats SHALL be contiguous, with no backpressure; the consumer SHALL always accept.
REQ-024 The rsp_last output SHALL be 1 only together with the Nth beat.
REQ-025 The RD_DRAIN state SHALL follow the last issue cycle and last until the last beat is delivered, then go to IDLE; req_ready SHALL be 1 in the cycle after rsp_last.
REQ-026 MemRead and MemWrite SHALL never be 1 in the same cycle.
REQ-027 When MemRead=MemWrite=0, MemAddr and Write_Data SHALL hold their last values.
REQ-028 A req_valid while req_ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-029 Changes to the req_* inputs after acceptance SHALL have no effect on the transfer in flight.

Reset
REQ-030 While reset=0 the block SHALL hold: state=IDLE, req_ready=1, MemRead=0, MemWrite=0, MemAddr=0, Write_Data=0, rsp_valid=0, rsp_rdata=0, rsp_last=0, wr_done=0.
REQ-031 If reset is asserted during a transfer, the block SHALL abort it immediately (asynchronously); no remaining beats or wr_done SHALL be produced.
REQ-032 After reset is released the block SHALL accept a new request on the first rising edge.

Verification
REQ-033 The bench SHALL check this scenario: write addr 0x40 data 0xDEADBEEF; MemWrite=1 with MemAddr=0x40 for exactly 1 cycle; wr_done pulses the next cycle; req_ready=1 again.
REQ-034 The bench SHALL check this scenario: read addr 0x40 len 0 after that write; one beat with rsp_rdata=0xDEADBEEF and rsp_last=1, two cycles after acceptance.
REQ-035 The bench SHALL check this scenario: read addr 0xFE len 3; MemAddr sequence 0xFE, 0xFF, 0x00, 0x01; 4 contiguous rsp_valid beats, rsp_last on the 4th.
REQ-036 The bench SHALL check this scenario: read len 15 with BURST_MAX=4; exactly 4 beats; req_valid held high during the burst is not accepted until req_ready returns.
REQ-037 The bench SHALL check this scenario: reset=0 in the 3rd issue cycle of an 8-beat read; all outputs go to their reset values at once, no further rsp_valid, and a new write accepted right after release.
REQ-038 The bench SHALL check this scenario: random request mix against a Data_Memory model; every read matches the last write to that address, and MemRead&MemWrite is never 1.
